// File: rtl/uarti_pkg.sv
// Shared types and default constants for the UART-receive word writer.
package uarti_pkg;

    typedef enum logic [1:0] {
        WAIT_H = 2'd0,
        WAIT_L = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } uarti_state_e;

    localparam int ADDR_W_DEF      = 10;
    localparam int WORD_COUNT_DEF  = 1024;
    localparam int TIMEOUT_CYC_DEF = 150000;
    localparam int TO_W_DEF        = 18;

endpackage

// File: rtl/uarti_sync_edge.sv
// Two-flop synchroniser for the clkout-domain byte strobe plus a rising-edge
// detector that yields a single-cycle byte_stb on clk_150_0.
module uarti_sync_edge (
    input  logic clk_150_0,
    input  logic reset,
    input  logic rdsig_uarti,
    output logic byte_stb
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rdsig_uarti;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_150_0 or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign byte_stb = sync_q & ~prev_q;

endmodule

// File: rtl/uarti_word_writer.sv
// Assembles received byte pairs (high first) into 16-bit words and writes them
// to sequential addresses over a req/ack port. Optional UARTI_CHECKSUM_EN adds
// a running 16-bit sum of all acknowledged words.
module uarti_word_writer
    import uarti_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WORD_COUNT  = WORD_COUNT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic              clk_150_0,
    input  logic              reset,
    input  logic              start_req,
    input  logic              end_req,
    input  logic [7:0]        dataout_uarti,
    input  logic              rdsig_uarti,
    output logic              write_req,
    output logic [ADDR_W-1:0] write_addr,
    output logic [15:0]       write_data,
    input  logic              write_ack,
    output logic              done,
    output logic              overrun,
    output logic              timeout_err
`ifdef UARTI_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    uarti_state_e      state_q, state_d;
    logic [TO_W-1:0]   timer_q, timer_d;
    logic [7:0]        high_q, high_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              to_err_q, to_err_d;
    logic              start_prev_q, start_prev_d;
`ifdef UARTI_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
`endif
    logic              byte_stb;
    logic              run;

    uarti_sync_edge u_sync_edge (
        .clk_150_0   (clk_150_0),
        .reset       (reset),
        .rdsig_uarti (rdsig_uarti),
        .byte_stb    (byte_stb)
    );

    assign run = start_req & ~end_req;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        high_d       = high_q;
        req_d        = req_q;
        addr_d       = addr_q;
        data_d       = data_q;
        done_d       = done_q;
        ovr_d        = ovr_q;
        to_err_d     = to_err_q;
        start_prev_d = start_req;
`ifdef UARTI_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        // With run low every state, including a pending request, is frozen.
        if (run) begin
            case (state_q)
                WAIT_H: begin
                    if (byte_stb) begin
                        high_d  = dataout_uarti;
                        timer_d = '0;
                        state_d = WAIT_L;
                    end else begin
                        state_d = WAIT_H;
                    end
                end
                WAIT_L: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (byte_stb) begin
                        data_d  = {high_q, dataout_uarti};
                        req_d   = 1'b1;
                        state_d = WRITE;
                    end else if (timer_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        to_err_d = 1'b1;
                        state_d  = WAIT_H;
                    end else begin
                        timer_d = timer_q + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                WRITE: begin
                    if (byte_stb) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                    if (write_ack) begin
                        req_d  = 1'b0;
                        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef UARTI_CHECKSUM_EN
                        sum_d  = sum_q + data_q;
`endif
                        if (addr_q == ADDR_W'(WORD_COUNT - 1)) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = WAIT_H;
                        end
                    end else begin
                        state_d = WRITE;
                    end
                end
                DONE: begin
                    if (start_req && !start_prev_q) begin
                        done_d   = 1'b0;
                        ovr_d    = 1'b0;
                        to_err_d = 1'b0;
                        addr_d   = '0;
`ifdef UARTI_CHECKSUM_EN
                        sum_d    = 16'h0000;
`endif
                        state_d  = WAIT_H;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = WAIT_H;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk_150_0 or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_H;
            timer_q      <= '0;
            high_q       <= 8'h00;
            req_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= 16'h0000;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
            to_err_q     <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef UARTI_CHECKSUM_EN
            sum_q        <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            high_q       <= high_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
            to_err_q     <= to_err_d;
            start_prev_q <= start_prev_d;
`ifdef UARTI_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign write_req   = req_q;
    assign write_addr  = addr_q;
    assign write_data  = data_q;
    assign done        = done_q;
    assign overrun     = ovr_q;
    assign timeout_err = to_err_q;
`ifdef UARTI_CHECKSUM_EN
    assign checksum    = sum_q;
`endif

endmodule

// File: doc/uarti_word_writer.md
Name: uarti_word_writer

Overview:
Receive-direction counterpart of the PROM-to-UART word streamer. Collects bytes from the UART receiver (high byte first, then low byte), assembles 16-bit words and writes them to sequential memory addresses through a req/ack write port. Runs entirely on clk_150_0; the receiver's byte strobe from the clkout domain is synchronised internally.

Parameters:
ADDR_W, 10, write address width
WORD_COUNT, 1024, words per transfer; done asserts after this many writes (1..2^ADDR_W)
TIMEOUT_CYC, 150000, max clk_150_0 cycles between high and low byte (1 ms)
TO_W, 18, timeout counter width (must hold TIMEOUT_CYC)

Ports:
clk_150_0  in  1  system clock
reset  in  1  async, active-low
start_req  in  1  run enable
end_req  in  1  stop; run = start_req & ~end_req
dataout_uarti  in  8  received byte, stable ≥4 clk_150_0 cycles after rdsig_uarti rises
rdsig_uarti  in  1  byte-valid strobe, clkout domain, high ≥1 clkout cycle
write_req  out  1  write request
write_addr  out  ADDR_W  word address
write_data  out  16  {high byte, low byte}
write_ack  in  1  one-cycle acknowledge from memory
done  out  1  sticky, WORD_COUNT words written
overrun  out  1  sticky, byte dropped while a write was pending
timeout_err  out  1  sticky, low byte missed the timeout window

Behaviour:
- Reset (async, active-low): write_req=0, write_addr=0, write_data=0, done=0, overrun=0, timeout_err=0, state=WAIT_H, timeout counter=0.
- Byte event: rdsig_uarti passes a 2-FF synchroniser; a rising edge on the synchronised signal gives a one-cycle byte_stb. dataout_uarti is sampled on byte_stb (3-cycle latency from the rdsig edge).
- States:
  - WAIT_H: on byte_stb, latch data[15:8], clear the timer, go to WAIT_L.
  - WAIT_L: timer increments each cycle. On byte_stb, latch data[7:0], set write_req=1 on the next edge, go to WRITE. If timer reaches TIMEOUT_CYC-1 with no byte, set timeout_err, discard the high byte, go to WAIT_H.
  - WRITE: write_req, write_addr and write_data hold stable until write_ack. On write_ack, write_req=0 in the same edge and write_addr increments. If the written word was number WORD_COUNT, set done and go to DONE; otherwise go to WAIT_H.
  - DONE: ignore all bytes; write_req stays 0.
- byte_stb in WRITE: byte dropped, overrun=1, the pending write is unaffected.
- byte_stb together with timeout expiry in the same cycle: the byte wins and no error is raised.
- write_ack while write_req=0: ignored.
- write_addr wraps from 2^ADDR_W-1 to 0 only when WORD_COUNT = 2^ADDR_W. done asserts on that same write.
- run low: all states are held frozen, including a pending write_req. Incoming bytes are discarded and do not set overrun.
- Rising edge of start_req while in DONE: clears done, overrun and timeout_err, resets write_addr to 0, goes to WAIT_H.
- Reset mid-write drops the transfer with no completion.

Optional Feature:
UARTI_CHECKSUM_EN:
- Defined: adds output checksum[15:0], reset 0. On each write_ack, checksum += write_data, mod 2^16. Cleared with the other sticky flags on restart.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package uarti_pkg: state enum (WAIT_H, WAIT_L, WRITE, DONE), 2-bit encoding, default parameter constants.
- Sub-module uarti_sync_edge: 2-FF synchroniser plus rising-edge detector producing byte_stb. Clock clk_150_0, same async active-low reset.

Test Plan:
- Bytes 0xA5 then 0x3C, ack after 5 cycles -> one write: addr 0, data 0xA53C. write_req high exactly until ack; addr becomes 1.
- WORD_COUNT=4, 8 bytes 0x01..0x08 -> writes 0x0102, 0x0304, 0x0506, 0x0708 at addr 0..3. done=1 after the 4th ack; a 9th byte causes no write.
- Byte 0x11, then no byte for TIMEOUT_CYC (test value 100) cycles -> timeout_err=1. Next pair 0x22, 0x33 writes 0x2233, proving 0x11 was discarded.
- Hold write_ack low; send 3rd byte 0x77 during WRITE -> overrun=1. The pending data is unchanged; 0x77 is never written.
- Drop end_req high mid-WAIT_L, send bytes, release -> no state change while stopped. Reset pulse during WRITE -> all outputs return to reset values immediately.
- With UARTI_CHECKSUM_EN, write 0xFFFF then 0x0002 -> checksum=0x0001.
